// File: rtl/usb_line_filter_pkg.sv
// Shared types for the USB line-state front end: PHY pin pair, decoded line
// state, and the {dp, dn} to line-state mapping for either bus speed.
package usb_line_filter_pkg;

  typedef struct packed {
    logic dp;
    logic dn;
  } d_port_t;

  typedef enum logic [1:0] {
    LS_SE0 = 2'd0,
    LS_J   = 2'd1,
    LS_K   = 2'd2,
    LS_SE1 = 2'd3
  } ls_t;

  // Low speed swaps the roles of dp and dn for J/K; SE0/SE1 are speed-agnostic.
  function automatic ls_t decode_ls(logic dp, logic dn, logic low_speed);
    case ({dp, dn})
      2'b00:   return LS_SE0;
      2'b11:   return LS_SE1;
      2'b10:   return low_speed ? LS_K : LS_J;
      default: return low_speed ? LS_J : LS_K;
    endcase
  endfunction

endpackage

// File: rtl/usb_line_filter_if.sv
// Bundle between the PHY pins and the NRZI decoder: raw pins in, filtered
// line information out.
interface usb_line_filter_if;
  import usb_line_filter_pkg::*;

  d_port_t d;
  logic    q;
  logic    se0;
  logic    se1;
  ls_t     line_state;
  logic    ls_change;
  logic    bus_reset;

  modport master (
    output d,
    input  q, se0, se1, line_state, ls_change, bus_reset
  );

  modport slave (
    input  d,
    output q, se0, se1, line_state, ls_change, bus_reset
  );

endinterface

// File: rtl/usb_filter_lane.sv
// One USB line: synchroniser chain, TAPS-deep sample window with a running
// popcount, and a hysteresis comparator producing the filtered level.
module usb_filter_lane #(
  parameter int   SYNC_STAGES = 2,
  parameter int   TAPS        = 5,
  parameter int   HYST        = 0,
  parameter logic IDLE        = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in,
  output logic out
);

  localparam int SW = $clog2(TAPS + 1);
  localparam logic [SW-1:0] SET_TH   = SW'((TAPS + 1) / 2 + HYST);
  localparam logic [SW-1:0] CLR_TH   = SW'((TAPS - 1) / 2 - HYST);
  localparam logic [SW-1:0] IDLE_SUM = IDLE ? SW'(TAPS) : '0;

  logic [SYNC_STAGES-1:0] sync;
  logic [TAPS-1:0]        taps;
  logic [SW-1:0]          sum;
  logic                   newest;
  logic                   oldest;

  assign newest = sync[SYNC_STAGES-1];
  assign oldest = taps[TAPS-1];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // NOTE: the window is reset to the idle level (not zero) so that sum
      // equals popcount(taps) from the very first edge and can never wrap.
      sync <= {SYNC_STAGES{IDLE}};
      taps <= {TAPS{IDLE}};
      sum  <= IDLE_SUM;
      out  <= IDLE;
    end else begin
      // NOTE: non-blocking assignments let every stage read the pre-edge
      // value of its neighbour, which is what makes this a shift register.
      sync <= SYNC_STAGES'({sync, in});
      taps <= TAPS'({taps, newest});
      sum  <= sum + SW'(newest) - SW'(oldest);
      if (sum >= SET_TH) begin
        out <= 1'b1;
      end else if (sum <= CLR_TH) begin
        out <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/usb_line_filter.sv
// USB line-state front end: filters dp/dn, decodes J/K/SE0/SE1, flags
// line-state changes and qualifies long SE0 as bus reset.
module usb_line_filter
  import usb_line_filter_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int TAPS         = 5,
  parameter int HYST         = 0,
  parameter int LOW_SPEED    = 0,
  parameter int RESET_CYCLES = 120
) (
  input  logic               clk,
  input  logic               reset_n,
  usb_line_filter_if.slave   bus
);

  localparam int             CW      = $clog2(RESET_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(RESET_CYCLES);
  localparam logic           IDLE_DP = (LOW_SPEED == 0);

  if (TAPS < 3 || TAPS > 15 || (TAPS % 2) == 0) begin : g_bad_taps
    $fatal(1, "usb_line_filter: TAPS must be odd and within 3..15");
  end
  if (HYST < 0 || HYST > (TAPS - 1) / 2) begin : g_bad_hyst
    $fatal(1, "usb_line_filter: HYST must be within 0..(TAPS-1)/2");
  end
  if (SYNC_STAGES < 1) begin : g_bad_sync
    $fatal(1, "usb_line_filter: SYNC_STAGES must be at least 1");
  end
  if (RESET_CYCLES < 1) begin : g_bad_reset
    $fatal(1, "usb_line_filter: RESET_CYCLES must be at least 1");
  end

  logic          o_dp;
  logic          o_dn;
  ls_t           ls_prev;
  logic [CW-1:0] se0_cnt;

  usb_filter_lane #(
    .SYNC_STAGES (SYNC_STAGES),
    .TAPS        (TAPS),
    .HYST        (HYST),
    .IDLE        (IDLE_DP)
  ) u_lane_dp (
    .clk     (clk),
    .reset_n (reset_n),
    .in      (bus.d.dp),
    .out     (o_dp)
  );

  usb_filter_lane #(
    .SYNC_STAGES (SYNC_STAGES),
    .TAPS        (TAPS),
    .HYST        (HYST),
    .IDLE        (!IDLE_DP)
  ) u_lane_dn (
    .clk     (clk),
    .reset_n (reset_n),
    .in      (bus.d.dn),
    .out     (o_dn)
  );

  assign bus.q          = o_dp;
  assign bus.se0        = ~o_dp & ~o_dn;
  assign bus.se1        =  o_dp &  o_dn;
  assign bus.line_state = decode_ls(o_dp, o_dn, !IDLE_DP);
  assign bus.bus_reset  = (se0_cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ls_prev       <= LS_J;
      bus.ls_change <= 1'b0;
      se0_cnt       <= '0;
    end else begin
      ls_prev       <= bus.line_state;
      bus.ls_change <= (bus.line_state != ls_prev);
      // Saturate rather than wrap so bus_reset stays high for an arbitrarily long SE0.
      if (!bus.se0) begin
        se0_cnt <= '0;
      end else if (se0_cnt != CNT_MAX) begin
        se0_cnt <= se0_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_usb_line_filter.sv
// Scoreboard bench: two filter configurations driven with directed and random
// pin activity, checked every cycle against a window-popcount reference model.
module tb_usb_line_filter;
  import usb_line_filter_pkg::*;

  localparam int MAXC = 4096;
  localparam int SA = 2, TA = 5, HA = 0, LA = 0, RA = 120;
  localparam int SB = 3, TB = 7, HB = 1, LB = 1, RB = 10;

  function automatic int p_s(int k); return (k == 0) ? SA : SB; endfunction
  function automatic int p_t(int k); return (k == 0) ? TA : TB; endfunction
  function automatic int p_h(int k); return (k == 0) ? HA : HB; endfunction
  function automatic int p_l(int k); return (k == 0) ? LA : LB; endfunction
  function automatic int p_r(int k); return (k == 0) ? RA : RB; endfunction

  typedef struct packed {
    logic q;
    logic se0;
    logic se1;
    ls_t  ls;
    logic chg;
    logic br;
  } obs_t;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  always #5 clk = ~clk;

  usb_line_filter_if if_a ();
  usb_line_filter_if if_b ();

  usb_line_filter #(
    .SYNC_STAGES (SA), .TAPS (TA), .HYST (HA), .LOW_SPEED (LA), .RESET_CYCLES (RA)
  ) dut_a (
    .clk     (clk),
    .reset_n (rst_a),
    .bus     (if_a)
  );

  usb_line_filter #(
    .SYNC_STAGES (SB), .TAPS (TB), .HYST (HB), .LOW_SPEED (LB), .RESET_CYCLES (RB)
  ) dut_b (
    .clk     (clk),
    .reset_n (rst_b),
    .bus     (if_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // The filtered level at edge n depends only on the last TAPS pin samples
  // that have cleared the synchroniser; anything at or before a reset edge
  // counts as idle.
  bit   hdp   [2][MAXC];
  bit   hdn   [2][MAXC];
  bit   rst_h [2][MAXC];
  ls_t  ls_h  [2][MAXC];
  int   last_rst [2];
  bit   m_dp [2];
  bit   m_dn [2];
  bit   m_se0_prev [2];
  int   m_run [2];
  obs_t exp_a[$];
  obs_t exp_b[$];
  int   n_edge = -1;

  function automatic bit hval(int k, int lane, int idx);
    bit idle = (lane == 0) ? (p_l(k) == 0) : (p_l(k) != 0);
    if (idx < 0 || idx <= last_rst[k]) return idle;
    return (lane == 0) ? hdp[k][idx] : hdn[k][idx];
  endfunction

  function automatic bit lane_level(int k, int lane, bit prev, int n);
    int ones = 0;
    for (int j = n - p_s(k) - p_t(k); j <= n - 1 - p_s(k); j++) ones += int'(hval(k, lane, j));
    if (ones >= (p_t(k) + 1) / 2 + p_h(k)) return 1'b1;
    if (ones <= (p_t(k) - 1) / 2 - p_h(k)) return 1'b0;
    return prev;
  endfunction

  function automatic ls_t ref_ls(int k, bit dp, bit dn);
    bit j_line_is_dp = (p_l(k) == 0);
    if (dp == dn) return dp ? LS_SE1 : LS_SE0;
    return (dp == j_line_is_dp) ? LS_J : LS_K;
  endfunction

  task automatic model_step(int k, int n, logic rstn, d_port_t d, output obs_t e);
    bit rst = (rstn !== 1'b1);
    hdp[k][n]   = d.dp;
    hdn[k][n]   = d.dn;
    rst_h[k][n] = rst;
    if (rst) begin
      last_rst[k] = n;
      m_dp[k]     = (p_l(k) == 0);
      m_dn[k]     = (p_l(k) != 0);
      m_run[k]    = 0;
    end else begin
      m_dp[k]  = lane_level(k, 0, m_dp[k], n);
      m_dn[k]  = lane_level(k, 1, m_dn[k], n);
      m_run[k] = m_se0_prev[k] ? m_run[k] + 1 : 0;
    end
    e.q   = m_dp[k];
    e.se0 = !m_dp[k] && !m_dn[k];
    e.se1 = m_dp[k] && m_dn[k];
    e.ls  = ref_ls(k, m_dp[k], m_dn[k]);
    ls_h[k][n] = e.ls;
    e.chg = !rst && n >= 2 && !rst_h[k][n-1] && (ls_h[k][n-1] != ls_h[k][n-2]);
    e.br  = (m_run[k] >= p_r(k));
    m_se0_prev[k] = e.se0;
  endtask

  initial begin
    obs_t e;
    last_rst = '{-1, -1};
    forever begin
      @(posedge clk);
      n_edge++;
      if (n_edge < MAXC) begin
        model_step(0, n_edge, rst_a, if_a.d, e);
        exp_a.push_back(e);
        model_step(1, n_edge, rst_b, if_b.d, e);
        exp_b.push_back(e);
      end
    end
  end

  // ---------------- monitor ----------------
  function automatic obs_t observe(logic q, logic se0, logic se1, ls_t ls, logic chg, logic br);
    obs_t o;
    o.q = q; o.se0 = se0; o.se1 = se1; o.ls = ls; o.chg = chg; o.br = br;
    return o;
  endfunction

  initial begin
    obs_t e;
    forever begin
      @(negedge clk);
      if (exp_a.size() > 0) begin
        e = exp_a.pop_front();
        check("scoreboard_a", 32'(observe(if_a.q, if_a.se0, if_a.se1, if_a.line_state,
                                          if_a.ls_change, if_a.bus_reset)), 32'(e));
      end
      if (exp_b.size() > 0) begin
        e = exp_b.pop_front();
        check("scoreboard_b", 32'(observe(if_b.q, if_b.se0, if_b.se1, if_b.line_state,
                                          if_b.ls_change, if_b.bus_reset)), 32'(e));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(int c);
    repeat (c) @(negedge clk);
  endtask

  task automatic square_b(int half, int reps);
    for (int r = 0; r < reps; r++) begin
      if_b.d = 2'b10; tick(half);
      if_b.d = 2'b00; tick(half);
    end
  endtask

  initial begin
    int   lat;
    int   pulses;
    int   low;
    int   tog;
    logic q_prev;
    int   rem_a;
    int   rem_b;

    rst_a = 1'b0; rst_b = 1'b0;
    if_a.d = 2'b10; if_b.d = 2'b01;
    tick(3);
    check("reset_q_a",   32'(if_a.q), 32'd1);
    check("reset_ls_a",  32'(if_a.line_state), 32'(LS_J));
    check("reset_se0_a", 32'(if_a.se0), 32'd0);
    check("reset_br_a",  32'(if_a.bus_reset), 32'd0);
    check("reset_chg_a", 32'(if_a.ls_change), 32'd0);
    check("reset_q_b",   32'(if_b.q), 32'd0);
    check("reset_ls_b",  32'(if_b.line_state), 32'(LS_J));
    rst_a = 1'b1; rst_b = 1'b1;
    tick(10);

    // Clean J to K step on the default configuration.
    if_a.d = 2'b01;
    lat = 0; pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (lat == 0 && if_a.q == 1'b0) lat = i;
      if (if_a.ls_change) pulses++;
    end
    check("step_latency", 32'(lat), 32'd6);
    check("step_ls_k", 32'(if_a.line_state), 32'(LS_K));
    check("step_pulses", 32'(pulses), 32'd1);
    @(negedge clk);

    // Glitch rejection: 2-sample dp dip is swallowed, 3-sample dip passes.
    if_a.d = 2'b10; tick(12);
    for (int g = 2; g <= 3; g++) begin
      if_a.d = 2'b00; tick(g); if_a.d = 2'b10;
      low = 0; pulses = 0;
      for (int i = 0; i < 20; i++) begin
        @(posedge clk); #1;
        if (if_a.q == 1'b0) low++;
        if (if_a.ls_change) pulses++;
      end
      @(negedge clk);
      check((g == 2) ? "glitch2_low" : "glitch3_low", 32'(low), (g == 2) ? 32'd0 : 32'd3);
      if (g == 2) check("glitch2_chg", 32'(pulses), 32'd0);
      tick(5);
    end

    // Bus reset on the default configuration (RESET_CYCLES = 120).
    if_a.d = 2'b00; tick(140);
    check("long_se0_br_a", 32'(if_a.bus_reset), 32'd1);
    if_a.d = 2'b10; tick(10);
    check("se0_end_br_a", 32'(if_a.bus_reset), 32'd0);

    // Hysteresis (TAPS=7, HYST=1): square waves of several widths, then alternation.
    square_b(4, 3);
    square_b(6, 3);
    square_b(5, 2);
    tog = 0; q_prev = if_b.q;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if_b.d = (i % 2 == 0) ? 2'b10 : 2'b00;
      if (i >= 12 && if_b.q !== q_prev) tog++;
      q_prev = if_b.q;
    end
    check("alternate_no_toggle", 32'(tog), 32'd0);

    // Bus reset with RESET_CYCLES = 10, low speed.
    if_b.d = 2'b01; tick(20);
    if_b.d = 2'b00; tick(25);
    check("long_se0_br_b", 32'(if_b.bus_reset), 32'd1);
    if_b.d = 2'b01; tick(20);
    check("se0_end_br_b", 32'(if_b.bus_reset), 32'd0);

    // Reset in the middle of an SE0 run, counter part-way to the threshold.
    if_b.d = 2'b00; tick(15);
    rst_b = 1'b0; tick(1);
    check("midrst_q_b",  32'(if_b.q), 32'd0);
    check("midrst_ls_b", 32'(if_b.line_state), 32'(LS_J));
    check("midrst_br_b", 32'(if_b.bus_reset), 32'd0);
    rst_b = 1'b1; if_b.d = 2'b10; tick(15);
    check("lowspeed_k_b", 32'(if_b.line_state), 32'(LS_K));

    // Random pin activity with short and long runs and occasional resets.
    rem_a = 0; rem_b = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      rst_a = ($urandom_range(0, 249) != 0);
      rst_b = ($urandom_range(0, 249) != 0);
      if (rem_a == 0) begin
        if_a.d = d_port_t'($urandom_range(0, 3));
        rem_a  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 30) : $urandom_range(1, 6);
      end
      if (rem_b == 0) begin
        if_b.d = d_port_t'($urandom_range(0, 3));
        rem_b  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 30) : $urandom_range(1, 6);
      end
      rem_a--; rem_b--;
    end
    rst_a = 1'b1; rst_b = 1'b1;
    tick(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
